xnor_eq_scheduler: RTL

XNOR_EQ_SCHEDULER -- requirements
Module: xnor_eq_scheduler

---
 rtl/xnor_eq_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/xnor_eq_scheduler.sv
// Round-robin scheduler sharing one external XNOR gate among four equality-compare requesters.
// Optional `EQ_EARLY_EXIT_EN: finish a compare on the first mismatching bit.
module xnor_eq_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] opa,
  input  logic [4*WIDTH-1:0] opb,
  output logic               gate_a,
  output logic               gate_b,
  input  logic               gate_x,
  output logic [3:0]         ack,
  output logic               eq,
  output logic               busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         ptr;
  logic [1:0]         gnt;
  logic [1:0]         win;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sa, sb;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               acc;
  logic               last_bit;

  // First requester at or after p, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign win = rr_pick(req, ptr);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i)) begin
        sel_a = opa[i*WIDTH +: WIDTH];
        sel_b = opb[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef EQ_EARLY_EXIT_EN
  assign last_bit = (cnt == CNT_W'(WIDTH-1)) || !gate_x;
`else
  assign last_bit = (cnt == CNT_W'(WIDTH-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gate_a    = 1'b0;
    gate_b    = 1'b0;
    ack       = 4'b0000;
    eq        = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (|req) state_nxt = SHIFT;
      end
      SHIFT: begin
        gate_a = sa[0];
        gate_b = sb[0];
        busy   = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        ack       = 4'b0001 << gnt;
        eq        = acc;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are latched only at capture, so requesters may change opa/opb mid-compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
      gnt <= 2'd0;
      cnt <= '0;
      sa  <= '0;
      sb  <= '0;
      acc <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt <= win;
            sa  <= sel_a;
            sb  <= sel_b;
            acc <= 1'b1;
            cnt <= '0;
          end
        end
        SHIFT: begin
          acc <= acc & gate_x;
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        DONE: begin
          ptr <= gnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
